branch_predictor: RTL and testbench

- Parametrised next-generation branch unit for the fetch/execute loop.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Fetch gets a predicted next PC with zero added latency.
- Execute reports resolved control-flow instructions. The block updates its tables, detects mispredictions and issues a registered redirect PC one cycle later.

---
 rtl/branch_predictor.sv | 141 ++++++++++++++
 tb/tb_branch_predictor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Fetch lookup is combinational;
// resolved instructions update the table and raise a registered one-cycle redirect.
module branch_predictor #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned ENTRIES      = 16,
   parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_pc_next,
   input  logic            resolve_valid,
   input  logic [XLEN-1:0] resolve_pc,
   input  logic            resolve_is_branch,
   input  logic            resolve_is_jump,
   input  logic            resolve_taken,
   input  logic [XLEN-1:0] resolve_target,
   input  logic            resolve_pred_taken,
   input  logic [XLEN-1:0] resolve_pred_pc_next,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     mispredict_count
);
   localparam int unsigned IDX  = $clog2(ENTRIES);
   localparam int unsigned TAGW = XLEN - IDX - 2;

   logic            valid_q  [ENTRIES];
   logic [TAGW-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0] target_q [ENTRIES];
   logic [1:0]      ctr_q    [ENTRIES];
   logic            isj_q    [ENTRIES];

   logic            mis_q, mis_d;
   logic [XLEN-1:0] redirect_q, redirect_d;
   logic [31:0]     count_q, count_d;

   // Fetch lookup; gated by rst so outputs are clean while reset is held.
   logic [IDX-1:0]  f_idx;
   logic [TAGW-1:0] f_tag;
   logic            f_hit;

   assign f_idx        = fetch_pc[IDX+1:2];
   assign f_tag        = fetch_pc[XLEN-1:IDX+2];
   assign f_hit        = !rst && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign pred_taken   = f_hit && (isj_q[f_idx] || ctr_q[f_idx][1]);
   assign pred_pc_next = pred_taken ? target_q[f_idx] : fetch_pc + XLEN'(4);

   logic [IDX-1:0]  r_idx;
   logic [TAGW-1:0] r_tag;
   logic            r_hit, r_jump, r_branch;
   logic            wr_en;
   logic            valid_d, isj_d;
   logic [TAGW-1:0] tag_d;
   logic [XLEN-1:0] target_d;
   logic [1:0]      ctr_d;

   assign r_idx    = resolve_pc[IDX+1:2];
   assign r_tag    = resolve_pc[XLEN-1:IDX+2];
   assign r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
   assign r_jump   = resolve_is_jump;
   assign r_branch = resolve_is_branch && !resolve_is_jump;

   always_comb begin
      wr_en    = 1'b0;
      valid_d  = valid_q[r_idx];
      tag_d    = tag_q[r_idx];
      target_d = target_q[r_idx];
      ctr_d    = ctr_q[r_idx];
      isj_d    = isj_q[r_idx];
      if (resolve_valid && (r_branch || r_jump)) begin
         if (r_hit) begin
            wr_en = 1'b1;
            if (r_jump) begin
               target_d = resolve_target;
               isj_d    = 1'b1;
            end else if (resolve_taken) begin
               target_d = resolve_target;
               if (ctr_q[r_idx] != 2'b11) ctr_d = ctr_q[r_idx] + 2'd1;
            end else if (ctr_q[r_idx] != 2'b00) begin
               ctr_d = ctr_q[r_idx] - 2'd1;
            end
         end else if (resolve_taken) begin
            wr_en    = 1'b1;
            valid_d  = 1'b1;
            tag_d    = r_tag;
            target_d = resolve_target;
            ctr_d    = r_jump ? 2'b11 : 2'b10;
            isj_d    = r_jump;
         end
      end
   end

   // Prediction-carried direction bit is implied by the carried next PC.
   logic            unused_pred_taken;
   logic [XLEN-1:0] actual_pc;

   assign unused_pred_taken = resolve_pred_taken;
   assign actual_pc         = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);

   always_comb begin
      mis_d      = resolve_valid && (actual_pc != resolve_pred_pc_next);
      redirect_d = mis_d ? actual_pc : redirect_q;
      count_d    = (mis_d && (count_q != '1)) ? count_q + 32'd1 : count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= COUNTER_INIT;
            isj_q[i]    <= 1'b0;
         end
      end else if (wr_en) begin
         valid_q[r_idx]  <= valid_d;
         tag_q[r_idx]    <= tag_d;
         target_q[r_idx] <= target_d;
         ctr_q[r_idx]    <= ctr_d;
         isj_q[r_idx]    <= isj_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q      <= 1'b0;
         redirect_q <= '0;
         count_q    <= '0;
      end else begin
         mis_q      <= mis_d;
         redirect_q <= redirect_d;
         count_q    <= count_d;
      end
   end

   assign mispredict       = mis_q;
   assign redirect_pc      = redirect_q;
   assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a table-level behavioural model,
// plus directed literal checks for the key scenarios.
module tb_branch_predictor;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_pc_next;
   logic        resolve_valid, resolve_is_branch, resolve_is_jump, resolve_taken;
   logic        resolve_pred_taken;
   logic [31:0] resolve_pc, resolve_target, resolve_pred_pc_next;
   logic        mispredict;
   logic [31:0] redirect_pc, mispredict_count;

   int unsigned ncmp = 0;
   int unsigned nerr = 0;
   bit          chk_on = 1'b1;

   branch_predictor #(.XLEN(32), .ENTRIES(16), .COUNTER_INIT(2'b01)) dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .pred_pc_next(pred_pc_next), .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
      .resolve_is_branch(resolve_is_branch), .resolve_is_jump(resolve_is_jump),
      .resolve_taken(resolve_taken), .resolve_target(resolve_target),
      .resolve_pred_taken(resolve_pred_taken), .resolve_pred_pc_next(resolve_pred_pc_next),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   // Behavioural model: 16 entries, index = (pc/4) mod 16, tag = pc/64.
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   bit          m_isj   [16];
   bit          m_mis;
   logic [31:0] m_redir, m_cnt;

   function automatic bit m_taken(input logic [31:0] pc);
      int unsigned i = (pc >> 2) % 16;
      return m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_isj[i] || m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_pred(input logic [31:0] pc);
      return m_taken(pc) ? m_tgt[(pc >> 2) % 16] : pc + 32'd4;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      logic [31:0] act;
      int unsigned i;
      bit          hit;
      if (rst) begin
         for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0; m_ctr[k] = 1; m_isj[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0;
         end
         m_mis = 1'b0; m_redir = '0; m_cnt = '0;
      end else begin
         act = resolve_taken ? resolve_target : resolve_pc + 32'd4;
         i   = (resolve_pc >> 2) % 16;
         hit = m_valid[i] && (m_tag[i] == (resolve_pc >> 6));
         m_mis = resolve_valid && (act != resolve_pred_pc_next);
         if (m_mis) begin
            m_redir = act;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         end
         if (resolve_valid && (resolve_is_branch || resolve_is_jump)) begin
            if (hit && resolve_is_jump) begin
               m_tgt[i] = resolve_target; m_isj[i] = 1'b1;
            end else if (hit) begin
               if (resolve_taken) begin
                  m_tgt[i] = resolve_target;
                  m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               end else begin
                  m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
               end
            end else if (resolve_taken) begin
               m_valid[i] = 1'b1; m_tag[i] = resolve_pc >> 6; m_tgt[i] = resolve_target;
               m_isj[i] = resolve_is_jump; m_ctr[i] = resolve_is_jump ? 3 : 2;
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("pred_taken", {31'd0, pred_taken}, {31'd0, m_taken(fetch_pc)});
         check("pred_pc_next", pred_pc_next, m_pred(fetch_pc));
         check("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
         check("redirect_pc", redirect_pc, m_redir);
         check("mispredict_count", mispredict_count, m_cnt);
      end
   end

   task automatic resolve(input logic [31:0] pc, input bit br, input bit jmp, input bit tk,
                          input logic [31:0] tgt, input logic [31:0] ppn);
      resolve_valid = 1'b1; resolve_pc = pc; resolve_is_branch = br; resolve_is_jump = jmp;
      resolve_taken = tk; resolve_target = tgt; resolve_pred_pc_next = ppn;
      resolve_pred_taken = (ppn != pc + 32'd4);
      @(posedge clk); #1;
      resolve_valid = 1'b0; resolve_is_branch = 1'b0; resolve_is_jump = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input bit exp_tk, input logic [31:0] exp_pc);
      fetch_pc = pc; #1;
      check("lit_pred_taken", {31'd0, pred_taken}, {31'd0, exp_tk});
      check("lit_pred_pc_next", pred_pc_next, exp_pc);
   endtask

   logic [31:0] pool [6];

   initial begin
      pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h180;
      pool[3] = 32'h204; pool[4] = 32'h1008; pool[5] = 32'hFFFF_FFFC;
      rst = 1'b1; fetch_pc = '0; resolve_valid = 1'b0; resolve_pc = '0;
      resolve_is_branch = 1'b0; resolve_is_jump = 1'b0; resolve_taken = 1'b0;
      resolve_target = '0; resolve_pred_taken = 1'b0; resolve_pred_pc_next = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      lookup(32'h100, 1'b0, 32'h104);
      check("lit_reset_mis", {31'd0, mispredict}, 32'd0);
      check("lit_reset_cnt", mispredict_count, 32'd0);

      resolve(32'h100, 1, 0, 1, 32'h80, 32'h104);
      check("lit_mis1", {31'd0, mispredict}, 32'd1);
      check("lit_redir1", redirect_pc, 32'h80);
      check("lit_cnt1", mispredict_count, 32'd1);
      lookup(32'h100, 1'b1, 32'h80);
      @(posedge clk); #1;
      check("lit_mis_drop", {31'd0, mispredict}, 32'd0);
      check("lit_redir_hold", redirect_pc, 32'h80);

      resolve(32'h100, 1, 0, 0, 32'h80, 32'h80);
      lookup(32'h100, 1'b0, 32'h104);
      repeat (5) resolve(32'h100, 1, 0, 1, 32'h80, 32'h80);
      resolve(32'h100, 1, 0, 0, 32'h80, 32'h80);
      lookup(32'h100, 1'b1, 32'h80);

      resolve(32'h140, 1, 0, 1, 32'h500, 32'h144);
      lookup(32'h100, 1'b0, 32'h104);
      lookup(32'h140, 1'b1, 32'h500);

      resolve(32'h200, 0, 1, 1, 32'h300, 32'h300);
      check("lit_jalr_nomis", {31'd0, mispredict}, 32'd0);
      lookup(32'h200, 1'b1, 32'h300);
      resolve(32'h200, 0, 1, 1, 32'h400, 32'h300);
      check("lit_jalr_mis", {31'd0, mispredict}, 32'd1);
      check("lit_jalr_redir", redirect_pc, 32'h400);
      lookup(32'h200, 1'b1, 32'h400);

      lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

      for (int n = 0; n < 800; n++) begin
         logic [31:0] pc, tgt, ppn;
         int unsigned sel;
         pc  = pool[$urandom_range(5)] | 32'($urandom_range(3));
         sel = $urandom_range(3);
         tgt = (sel == 0) ? 32'h80 : (sel == 1) ? 32'h400 : ($urandom & 32'hFFFF_FFFC);
         sel = $urandom_range(3);
         ppn = (sel == 0) ? pc + 32'd4 : (sel == 1) ? tgt : (sel == 2) ? m_pred(pc) : $urandom;
         fetch_pc             = pool[$urandom_range(5)] | 32'($urandom_range(3));
         resolve_valid        = ($urandom_range(9) < 7);
         resolve_pc           = pc;
         resolve_is_branch    = $urandom_range(1) == 1;
         resolve_is_jump      = $urandom_range(3) == 0;
         resolve_taken        = resolve_is_jump ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
         resolve_target       = tgt;
         resolve_pred_pc_next = ppn;
         resolve_pred_taken   = $urandom_range(1) == 1;
         @(posedge clk); #1;
      end

      resolve_valid = 1'b1; resolve_is_branch = 1'b1; resolve_taken = 1'b1;
      resolve_pc = 32'h140; resolve_target = 32'h999C; resolve_pred_pc_next = 32'h0;
      rst = 1'b1; #1;
      check("lit_rst_mis", {31'd0, mispredict}, 32'd0);
      check("lit_rst_cnt", mispredict_count, 32'd0);
      check("lit_rst_redir", redirect_pc, 32'd0);
      lookup(32'h100, 1'b0, 32'h104);
      lookup(32'h200, 1'b0, 32'h204);
      @(posedge clk); #1;
      rst = 1'b0; resolve_valid = 1'b0;
      lookup(32'h140, 1'b0, 32'h144);
      repeat (3) @(posedge clk);
      #1 chk_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
